// File: rtl/decode_pkg.sv
// Shared types for the RV64I decode stage: ALU ops, instruction formats, memory
// access kinds and the decoded record handed to execute.
package decode_pkg;

  // Record fields are sized for the widest datapath; narrower builds zero-extend pc/target.
  localparam int MAX_W = 64;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {TYPE_R, TYPE_I, TYPE_S, TYPE_SB, TYPE_U, TYPE_UJ} instr_type_e;

  typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_access_e;

  typedef enum logic [2:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D, SIZE_BU, SIZE_HU, SIZE_WU} mem_size_e;

  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [MAX_W-1:0] imm;
    alu_op_e          alu_op;
    instr_type_e      instr_type;
    logic             reg_write;
    mem_access_e      mem_access;
    mem_size_e        mem_size;
    logic             word_op;
    logic             illegal;
    logic [MAX_W-1:0] pc;
    logic [MAX_W-1:0] target;
  } decoded_t;

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV64I field decode. Define DECODE_RV64M_EN to accept the
// M-extension encodings (func7=0000001) on OP/OP-32; otherwise they decode as illegal.
module decode_core
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr,
  output decoded_t    dec,
  output logic        has_target
);

  localparam bit IS_64 = (XLEN == 64);

  logic [6:0]       opcode;
  logic [6:0]       funct7;
  logic [2:0]       funct3;
  logic [MAX_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt, shamt_w;
  logic             shift_lo, shift_ar;
  logic             ok;
  decoded_t         d;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{(MAX_W-12){instr[31]}}, instr[31:20]};
  assign imm_s   = {{(MAX_W-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{(MAX_W-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {{(MAX_W-32){instr[31]}}, instr[31:12], 12'h000};
  assign imm_j   = {{(MAX_W-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt_w = {{(MAX_W-5){1'b0}}, instr[24:20]};
  assign shamt   = IS_64 ? {{(MAX_W-6){1'b0}}, instr[25:20]} : shamt_w;
  // On RV64 the shift-immediate shamt borrows bit 25, so only bits 31:26 qualify the op.
  assign shift_lo = IS_64 ? (instr[31:26] == 6'b000000) : (funct7 == 7'b0000000);
  assign shift_ar = IS_64 ? (instr[31:26] == 6'b010000) : (funct7 == 7'b0100000);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    d          = '0;
    ok         = 1'b1;
    has_target = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        d.instr_type = TYPE_U;
        d.imm        = imm_u;
        d.reg_write  = 1'b1;
        has_target   = (opcode == OPC_AUIPC);
      end
      OPC_JAL: begin
        d.instr_type = TYPE_UJ;
        d.imm        = imm_j;
        d.reg_write  = 1'b1;
        has_target   = 1'b1;
      end
      OPC_JALR: begin
        d.instr_type = TYPE_I;
        d.imm        = imm_i;
        d.reg_write  = 1'b1;
        ok           = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.instr_type = TYPE_SB;
        d.imm        = imm_b;
        has_target   = 1'b1;
        case (funct3)
          3'b000:  d.alu_op = ALU_BEQ;
          3'b001:  d.alu_op = ALU_BNE;
          3'b100:  d.alu_op = ALU_BLT;
          3'b101:  d.alu_op = ALU_BGE;
          3'b110:  d.alu_op = ALU_BLTU;
          3'b111:  d.alu_op = ALU_BGEU;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.instr_type = TYPE_I;
        d.imm        = imm_i;
        d.reg_write  = 1'b1;
        d.mem_access = MEM_LOAD;
        case (funct3)
          3'b000:  d.mem_size = SIZE_B;
          3'b001:  d.mem_size = SIZE_H;
          3'b010:  d.mem_size = SIZE_W;
          3'b011:  begin d.mem_size = SIZE_D;  ok = IS_64; end
          3'b100:  d.mem_size = SIZE_BU;
          3'b101:  d.mem_size = SIZE_HU;
          3'b110:  begin d.mem_size = SIZE_WU; ok = IS_64; end
          default: ok = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.instr_type = TYPE_S;
        d.imm        = imm_s;
        d.mem_access = MEM_STORE;
        case (funct3)
          3'b000:  d.mem_size = SIZE_B;
          3'b001:  d.mem_size = SIZE_H;
          3'b010:  d.mem_size = SIZE_W;
          3'b011:  begin d.mem_size = SIZE_D; ok = IS_64; end
          default: ok = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        d.instr_type = TYPE_I;
        d.imm        = imm_i;
        d.reg_write  = 1'b1;
        case (funct3)
          3'b000: d.alu_op = ALU_ADD;
          3'b010: d.alu_op = ALU_SLT;
          3'b011: d.alu_op = ALU_SLTU;
          3'b100: d.alu_op = ALU_XOR;
          3'b110: d.alu_op = ALU_OR;
          3'b111: d.alu_op = ALU_AND;
          3'b001: begin d.alu_op = ALU_SLL; d.imm = shamt; ok = shift_lo; end
          default: begin
            d.alu_op = shift_ar ? ALU_SRA : ALU_SRL;
            d.imm    = shamt;
            ok       = shift_lo || shift_ar;
          end
        endcase
      end
      OPC_OP_IMM_32: begin
        d.instr_type = TYPE_I;
        d.imm        = imm_i;
        d.reg_write  = 1'b1;
        d.word_op    = 1'b1;
        case (funct3)
          3'b000:  d.alu_op = ALU_ADD;
          3'b001:  begin d.alu_op = ALU_SLL; d.imm = shamt_w; ok = (funct7 == 7'b0000000); end
          3'b101: begin
            d.alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            d.imm    = shamt_w;
            ok       = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: ok = 1'b0;
        endcase
        if (!IS_64) ok = 1'b0;
      end
      OPC_OP, OPC_OP_32: begin
        d.instr_type = TYPE_R;
        d.reg_write  = 1'b1;
        d.word_op    = (opcode == OPC_OP_32);
        case (funct7)
          7'b0000000: begin
            case (funct3)
              3'b000:  d.alu_op = ALU_ADD;
              3'b001:  d.alu_op = ALU_SLL;
              3'b010:  d.alu_op = ALU_SLT;
              3'b011:  d.alu_op = ALU_SLTU;
              3'b100:  d.alu_op = ALU_XOR;
              3'b101:  d.alu_op = ALU_SRL;
              3'b110:  d.alu_op = ALU_OR;
              default: d.alu_op = ALU_AND;
            endcase
            if (d.word_op && !(funct3 inside {3'b000, 3'b001, 3'b101})) ok = 1'b0;
          end
          7'b0100000: begin
            if (funct3 == 3'b000)      d.alu_op = ALU_SUB;
            else if (funct3 == 3'b101) d.alu_op = ALU_SRA;
            else                       ok = 1'b0;
          end
`ifdef DECODE_RV64M_EN
          7'b0000001: begin
            // funct3 order matches the MUL..REMU enum order.
            d.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
            if (d.word_op && (funct3 inside {3'b001, 3'b010, 3'b011})) ok = 1'b0;
          end
`endif
          default: ok = 1'b0;
        endcase
        if (d.word_op && !IS_64) ok = 1'b0;
      end
      default: ok = 1'b0;
    endcase

    if (!ok) begin
      d          = '0;
      d.illegal  = 1'b1;
      has_target = 1'b0;
    end
    d.rd  = instr[11:7];
    d.rs1 = instr[19:15];
    d.rs2 = instr[24:20];
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    dec = d;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decode_core plus target adder feeding a 2-entry skid
// buffer. Optional M-extension decode is enabled with DECODE_RV64M_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output decoded_t        out_dec
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  localparam logic [MAX_W-1:0] PC_MASK =
    (PC_W >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << PC_W) - MAX_W'(1));

  state_e           state, state_n;
  decoded_t         core_dec, in_rec, main_q, skid_q;
  logic             has_target;
  logic [MAX_W-1:0] pc_ext;
  logic             in_fire, out_fire;
  logic             load_main, main_from_skid, load_skid;

  decode_core #(.XLEN(XLEN)) u_core (
    .instr      (in_instr),
    .dec        (core_dec),
    .has_target (has_target)
  );

  assign pc_ext = MAX_W'(in_pc);

  always_comb begin
    in_rec        = core_dec;
    in_rec.pc     = pc_ext;
    in_rec.target = has_target ? ((pc_ext + core_dec.imm) & PC_MASK) : '0;
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_dec   = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin state_n = ONE; load_main = 1'b1; end
        ONE: begin
          if (in_fire && out_fire)  load_main = 1'b1;
          else if (in_fire)         begin state_n = TWO; load_skid = 1'b1; end
          else if (out_fire)        state_n = EMPTY;
        end
        TWO: if (out_fire) begin state_n = ONE; main_from_skid = 1'b1; end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the record registers are reset too, so out_dec reads all-zero straight after reset.
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      // NOTE: non-blocking so main_q picks up the pre-edge skid_q when draining.
      state <= state_n;
      if (load_main)           main_q <= in_rec;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_rec;
    end
  end

endmodule
